// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive IO port: receiver states,
// register-select codes and STATUS bit layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic UART_REG_DATA   = 1'b0;
    localparam logic UART_REG_STATUS = 1'b1;

    localparam int ST_NE   = 0;
    localparam int ST_OVR  = 1;
    localparam int ST_FERR = 2;

    function automatic logic [15:0] status_word(input logic ne, input logic ovr, input logic ferr);
        logic [15:0] w;
        w          = '0;
        w[ST_NE]   = ne;
        w[ST_OVR]  = ovr;
        w[ST_FERR] = ferr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// DEPTH x 8 synchronous FIFO with wrap-bit pointers. The head byte is exposed
// combinationally so the CPU sees it in the same cycle it issues the read.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_io.sv
// Memory-mapped 8N1 UART receiver: synchroniser, bit-timing FSM, byte FIFO and
// the DATA/STATUS read mux feeding the CPU IO read path.
module uart_rx_io
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 23_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        iUartFromPc,
    input  logic        iUartCtrl,
    input  logic        iIoRead,
    input  logic        iAddrSel,
    output logic [15:0] oUartData
);

    localparam int BIT_CNT = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    logic            push, ferr_set, ovr_set;
    logic            data_rd, status_rd, pop;
    logic [7:0]      head;
    logic            full, empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q & ~sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-start-bit check rejects short low glitches.
                if (cnt_q == CNT_HALF) begin
                    if (!sync2_q) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    push     = sync2_q;
                    ferr_set = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_rd   = iUartCtrl & iIoRead & (iAddrSel == UART_REG_DATA);
    assign status_rd = iUartCtrl & iIoRead & (iAddrSel == UART_REG_STATUS);
    assign pop       = data_rd & ~empty;
    assign ovr_set   = push & full & ~pop;

    // A fresh error in the clearing cycle keeps the flag set.
    assign ferr_d = ferr_set | (ferr_q & ~status_rd);
    assign ovr_d  = ovr_set  | (ovr_q  & ~status_rd);

    always_ff @(posedge clock) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= iUartFromPc;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .din   (shift_q),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        oUartData = 16'h0000;
        if (data_rd) begin
            if (!empty) oUartData = {7'b0, 1'b1, head};
        end else if (status_rd) begin
            oUartData = status_word(~empty, ovr_q, ferr_q);
        end
    end

endmodule

// File: tb/tb_uart_rx_io.sv
// Directed bench for uart_rx_io at 16 clocks per bit: single frame, overflow,
// framing error, start glitch, simultaneous push/pop and reset mid-frame.
module tb_uart_rx_io;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        rx_line = 1'b1;
    logic        uart_ctrl = 1'b0;
    logic        io_read = 1'b0;
    logic        addr_sel = 1'b0;
    logic [15:0] uart_data;

    int checks = 0;
    int failures = 0;

    uart_rx_io #(
        .CLK_HZ (1_600_000),
        .BAUD   (100_000),
        .DEPTH  (4)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .iUartFromPc (rx_line),
        .iUartCtrl   (uart_ctrl),
        .iIoRead     (io_read),
        .iAddrSel    (addr_sel),
        .oUartData   (uart_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end else begin
            $display("ok   %s got=%h", tag, obs);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clock);
        #1 rx_line = 1'b0;
        repeat (16) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #1 rx_line = b[i];
            repeat (16) @(posedge clock);
        end
        #1 rx_line = stop_bit;
        repeat (16) @(posedge clock);
        #1 rx_line = 1'b1;
    endtask

    task automatic io_rd(input logic sel, output logic [15:0] d);
        @(posedge clock);
        #1;
        uart_ctrl = 1'b1;
        io_read   = 1'b1;
        addr_sel  = sel;
        #3 d = uart_data;
        @(posedge clock);
        #1;
        uart_ctrl = 1'b0;
        io_read   = 1'b0;
        addr_sel  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  fill [4];
        logic [7:0]  b6;
        fill = '{8'h11, 8'h22, 8'h33, 8'h44};
        b6   = 8'h5A;

        repeat (4) @(posedge clock);
        #1 rst = 1'b0;
        #3 chk("reset_unselected", uart_data, 16'h0000);
        io_rd(1'b1, d); chk("reset_status", d, 16'h0000);

        // 1: single frame
        send_frame(8'hA5, 1'b1);
        io_rd(1'b0, d); chk("t1_data", d, 16'h01A5);
        io_rd(1'b0, d); chk("t1_data_empty", d, 16'h0000);
        io_rd(1'b1, d); chk("t1_status", d, 16'h0000);

        // 2: overflow
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(posedge clock);
        io_rd(1'b1, d); chk("t2_status_ovr", d, 16'h0003);
        for (int i = 1; i <= 4; i++) begin
            io_rd(1'b0, d); chk($sformatf("t2_data%0d", i), d, 16'h0100 | 16'(i));
        end
        io_rd(1'b0, d); chk("t2_data_empty", d, 16'h0000);
        io_rd(1'b1, d); chk("t2_status_clr", d, 16'h0000);

        // 3: framing error
        send_frame(8'h3C, 1'b0);
        repeat (4) @(posedge clock);
        io_rd(1'b1, d); chk("t3_status_ferr", d, 16'h0004);
        io_rd(1'b1, d); chk("t3_status_clr", d, 16'h0000);
        io_rd(1'b0, d); chk("t3_data_empty", d, 16'h0000);

        // 4: start glitch
        @(posedge clock);
        #1 rx_line = 1'b0;
        repeat (8) @(posedge clock);
        #1 rx_line = 1'b1;
        repeat (40) @(posedge clock);
        io_rd(1'b1, d); chk("t4_status_glitch", d, 16'h0000);
        send_frame(8'h5A, 1'b1);
        io_rd(1'b0, d); chk("t4_data", d, 16'h015A);

        // 5: pop coinciding with the stop-sample edge of a fifth byte
        for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1);
        repeat (4) @(posedge clock);
        fork
            send_frame(8'h77, 1'b1);
            begin
                @(negedge rx_line);
                repeat (154) @(posedge clock);
                #1;
                uart_ctrl = 1'b1;
                io_read   = 1'b1;
                addr_sel  = 1'b0;
                #3 chk("t5_data_simul", uart_data, 16'h0111);
                @(posedge clock);
                #1;
                uart_ctrl = 1'b0;
                io_read   = 1'b0;
            end
        join
        repeat (4) @(posedge clock);
        io_rd(1'b1, d); chk("t5_status", d, 16'h0001);
        io_rd(1'b0, d); chk("t5_data_b1", d, 16'h0122);
        io_rd(1'b0, d); chk("t5_data_b2", d, 16'h0133);
        io_rd(1'b0, d); chk("t5_data_b3", d, 16'h0144);
        io_rd(1'b0, d); chk("t5_data_b4", d, 16'h0177);

        // 6: reset during data bit 3
        @(posedge clock);
        #1 rx_line = 1'b0;
        repeat (16) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            #1 rx_line = b6[i];
            repeat (16) @(posedge clock);
        end
        #1 rx_line = b6[3];
        repeat (8) @(posedge clock);
        #1 rst = 1'b1;
        @(posedge clock);
        #1 rst = 1'b0;
        rx_line = 1'b1;
        repeat (120) @(posedge clock);
        io_rd(1'b1, d); chk("t6_status", d, 16'h0000);
        io_rd(1'b0, d); chk("t6_data_empty", d, 16'h0000);
        send_frame(8'hC3, 1'b1);
        io_rd(1'b0, d); chk("t6_data", d, 16'h01C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
